// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port front end for a single-port RAM.
// Ports A and B issue read/write requests; one access is in flight at a time.
// Ties are resolved round-robin unless ARB_FIXED_PRIO_EN is defined, in which
// case port A always wins a tie. Reads complete two cycles after the grant.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  r_port_b;      // port owning the access in flight
  logic                  r_gnt_a;
  logic                  r_gnt_b;
  logic                  r_rvalid_a;
  logic                  r_rvalid_b;
  logic [DATA_WIDTH-1:0] r_rdata_a;
  logic [DATA_WIDTH-1:0] r_rdata_b;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ram_we;
  logic                  r_busy;
`ifndef ARB_FIXED_PRIO_EN
  logic                  r_last_grant_b; // 1 = B was granted most recently
`endif

  // Next-state and winner selection; requests are only looked at in IDLE
  always_comb begin
    w_next_state = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_a && req_b) begin
`ifdef ARB_FIXED_PRIO_EN
          w_grant_a = 1'b1;
`else
          if (r_last_grant_b) begin
            w_grant_a = 1'b1;
          end else begin
            w_grant_b = 1'b1;
          end
`endif
          w_next_state = S_ISSUE;
        end else if (req_a) begin
          w_grant_a    = 1'b1;
          w_next_state = S_ISSUE;
        end else if (req_b) begin
          w_grant_b    = 1'b1;
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        // a write is done once ram_we has been presented for one cycle
        if (r_ram_we) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Round-robin memory: remembers which port received the latest grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant_b <= 1'b1;
    end else if (w_grant_a || w_grant_b) begin
      r_last_grant_b <= w_grant_b;
    end
  end
`endif

  // Registered grants, RAM command, busy and read-return path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_port_b   <= 1'b0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_gnt_a    <= w_grant_a;
      r_gnt_b    <= w_grant_b;
      r_busy     <= (w_next_state != S_IDLE);
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      if (w_grant_a) begin
        r_port_b   <= 1'b0;
        r_ram_we   <= we_a;
        r_ram_addr <= addr_a;
        r_ram_data <= wdata_a;
      end else if (w_grant_b) begin
        r_port_b   <= 1'b1;
        r_ram_we   <= we_b;
        r_ram_addr <= addr_b;
        r_ram_data <= wdata_b;
      end else begin
        // address and data hold; the write strobe lives for ISSUE only
        r_ram_we <= 1'b0;
      end
      // ram_q is valid during WAIT; hand it to the port that issued the read
      if (r_state == S_WAIT) begin
        if (r_port_b) begin
          r_rdata_b  <= ram_q;
          r_rvalid_b <= 1'b1;
        end else begin
          r_rdata_a  <= ram_q;
          r_rvalid_a <= 1'b1;
        end
      end
    end
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign ram_we   = r_ram_we;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed reset/latency sequences, then
// randomized request rounds checked by a queue scoreboard against a
// transaction-level model (grant order, cycle timing, memory contents).
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          busy;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // single-port RAM, registered address, write-first
  logic [DW-1:0] mem [64] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      ram_q         <= ram_data;
    end else begin
      ram_q <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    int            cyc;
  } gexp_t;
  typedef struct {
    bit            port_b;
    logic [DW-1:0] data;
    int            cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  // reference model state
  logic [DW-1:0] m_mem [64] = '{default: 8'h00};
  bit            m_last_b = 1'b1;

  // monitor: compares every grant and read return against the expectations
  always @(negedge clk) begin
    if (sb_on) begin
      if (gnt_a && gnt_b) chk("gnt_exclusive", 32'd1, 32'd0);
      if (rvalid_a && rvalid_b) chk("rvalid_exclusive", 32'd1, 32'd0);
      if (gnt_a || gnt_b) begin
        if (gq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_gnt: got gnt_a=%0b gnt_b=%0b expected none", gnt_a, gnt_b);
        end else begin
          gexp_t e;
          e = gq.pop_front();
          chk("gnt_port", {31'd0, gnt_b}, {31'd0, e.port_b});
          chk("gnt_cycle", cyc, e.cyc);
          chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
          chk("ram_addr", {26'd0, ram_addr}, {26'd0, e.addr});
          if (e.we) chk("ram_data", {24'd0, ram_data}, {24'd0, e.data});
          else rq.push_back('{port_b: e.port_b, data: e.rdata, cyc: e.cyc + 2});
        end
      end
      if (rvalid_a || rvalid_b) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rvalid: got rvalid_a=%0b rvalid_b=%0b expected none", rvalid_a, rvalid_b);
        end else begin
          rexp_t r;
          r = rq.pop_front();
          chk("rvalid_port", {31'd0, rvalid_b}, {31'd0, r.port_b});
          chk("rvalid_cycle", cyc, r.cyc);
          chk("rdata", {24'd0, (rvalid_b ? rdata_b : rdata_a)}, {24'd0, r.data});
        end
      end
    end
  end

  // one round: chosen ports raise requests together; model predicts the rest
  task automatic do_round(input bit ra, input bit rb, input bit wa, input bit wb,
                          input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                          input logic [DW-1:0] da, input logic [DW-1:0] db);
    bit order [2];
    int n;
    int t;
    bit done;
    n = 0;
    if (ra && rb) begin
`ifdef ARB_FIXED_PRIO_EN
      order[0] = 1'b0;
`else
      order[0] = m_last_b ? 1'b0 : 1'b1;
`endif
      order[1] = ~order[0];
      n = 2;
    end else if (ra || rb) begin
      order[0] = rb;
      n = 1;
    end
    t = cyc + 1;
    for (int i = 0; i < n; i++) begin
      gexp_t e;
      e.port_b = order[i];
      e.we     = order[i] ? wb : wa;
      e.addr   = order[i] ? ab : aa;
      e.data   = order[i] ? db : da;
      e.rdata  = e.we ? 8'h00 : m_mem[e.addr];
      if (e.we) m_mem[e.addr] = e.data;
      e.cyc = t;
      t += e.we ? 2 : 3;
      m_last_b = order[i];
      gq.push_back(e);
    end
    req_a = ra; req_b = rb; we_a = wa; we_b = wb;
    addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
      done = !req_a && !req_b;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: got req_a=%0b req_b=%0b still pending expected granted", req_a, req_b);
      req_a = 1'b0; req_b = 1'b0;
    end
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("rst_busy_we", {30'd0, busy, ram_we}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_a, rdata_b}, 32'd0);
    chk("rst_ram", {18'd0, ram_addr, ram_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0x3C to address 5 from A, request held one cycle
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 8'h3C;
    @(negedge clk);
    req_a = 1'b0;
    chk("w_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("w_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("w_ram_we", {31'd0, ram_we}, 32'd1);
    chk("w_ram_addr", {26'd0, ram_addr}, 32'd5);
    chk("w_ram_data", {24'd0, ram_data}, 32'h3C);
    chk("w_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("w_busy_end", {31'd0, busy}, 32'd0);
    chk("w_we_end", {31'd0, ram_we}, 32'd0);

    // read it back on B
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd5;
    @(negedge clk);
    req_b = 1'b0;
    chk("r_gnt_b", {31'd0, gnt_b}, 32'd1);
    @(negedge clk);
    chk("r_rvalid_wait", {31'd0, rvalid_b}, 32'd0);
    chk("r_ram_addr_hold", {26'd0, ram_addr}, 32'd5);
    @(negedge clk);
    chk("r_rvalid_b", {31'd0, rvalid_b}, 32'd1);
    chk("r_rdata_b", {24'd0, rdata_b}, 32'h3C);
    chk("r_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);

    // reset during WAIT of a read on A aborts it
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd5;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    chk("abort_rdata_a", {24'd0, rdata_a}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rvalid_late", {31'd0, rvalid_a}, 32'd0);

    // scoreboard phase
    m_mem[5] = 8'h3C;
    m_last_b = 1'b1;
    sb_on = 1'b1;
    do_round(1'b1, 1'b0, 1'b1, 1'b0, 6'd63, 6'd0, 8'hFF, 8'h00);
    do_round(1'b1, 1'b0, 1'b0, 1'b0, 6'd63, 6'd0, 8'h00, 8'h00);
    do_round(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 8'h00, 8'h00);
    do_round(1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 6'd63, 8'h00, 8'h00);
    do_round(1'b1, 1'b1, 1'b0, 1'b0, 6'd63, 6'd5, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      do_round(mode != 1, mode != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
               8'($urandom), 8'($urandom));
    end
    repeat (4) @(negedge clk);
    chk("gq_drained", gq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_a, req_b  in  1 each  SHALL be the access requests of ports A and B.
REQ-006 we_a, we_b  in  1 each  SHALL select the access type: 1 = write, 0 = read.
REQ-007 addr_a, addr_b  in  ADDR_WIDTH each  SHALL be the request addresses.
REQ-008 wdata_a, wdata_b  in  DATA_WIDTH each  SHALL be the write data.
REQ-009 gnt_a, gnt_b  out  1 each  SHALL be the registered one-cycle grant pulses.
REQ-010 rvalid_a, rvalid_b  out  1 each  SHALL be the registered one-cycle read-data-valid pulses.
REQ-011 rdata_a, rdata_b  out  DATA_WIDTH each  SHALL be the registered read data, held until the next read completion on that port.
REQ-012 ram_addr, ram_data, ram_we  out  ADDR_WIDTH, DATA_WIDTH, 1  SHALL drive the single-port RAM (registered read address, new-data-on-write).
REQ-013 ram_q  in  DATA_WIDTH  SHALL be the RAM read data, valid the cycle after the address edge.
REQ-014 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT: IDLE->ISSUE on any req; ISSUE->IDLE for a write; ISSUE->WAIT for a read; WAIT->IDLE unconditionally.
REQ-016 Requests SHALL be sampled only in IDLE; req high in IDLE is a new request.
REQ-017 On the IDLE->ISSUE edge, the winner's we/addr/wdata SHALL be latched into ram_we/ram_addr/ram_data, and the winner's gnt SHALL be 1 for the ISSUE cycle only.
REQ-018 A requester SHALL drop req within the gnt cycle; req still high when IDLE is next entered is a second request.
REQ-019 ram_we SHALL be 1 only in ISSUE of a write; 0 in all other states.
REQ-020 ram_addr SHALL hold its value through WAIT.
REQ-021 Read: ram_q SHALL be captured into rdata_x on the WAIT->IDLE edge; rvalid_x SHALL pulse for the following cycle, coinciding with the next IDLE.
REQ-022 Latency from req sampled (cycle 0): gnt cycle 1; write lands on edge ending cycle 1; read rvalid/rdata in cycle 3.
REQ-023 Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-024 Round-robin: on simultaneous req_a and req_b, the port not granted last SHALL win; a single requester always wins; last_grant SHALL update on every grant.
REQ-025 The losing request SHALL wait, holding its signals, and SHALL be granted at the next IDLE if still asserted.
REQ-026 gnt_a and gnt_b SHALL never be high together; rvalid SHALL go only to the port that issued the read.

Reset
REQ-027 With rst_n low at posedge clk: state IDLE, gnt_*, rvalid_*, ram_we, busy = 0; rdata_*, ram_addr, ram_data = 0; last_grant = B, so A wins the first tie.
REQ-028 Reset in ISSUE or WAIT SHALL abort the access; no rvalid SHALL follow; a write in ISSUE during reset SHALL not be issued (ram_we = 0).

Configuration
REQ-029 With macro ARB_FIXED_PRIO_EN defined, port A SHALL always win ties and last_grant is unused; without it, round-robin per REQ-024 applies.

Verification
REQ-030 Reset; req_a=1, we_a=1, addr_a=5, wdata_a=0x3C one cycle -> gnt_a in cycle 1, ram_we=1, ram_addr=5, ram_data=0x3C; busy for 1 cycle.
REQ-031 After REQ-030, req_b read addr 5 -> gnt_b cycle 1, rvalid_b cycle 3, rdata_b=0x3C; rvalid_a stays 0.
REQ-032 req_a and req_b both held, reads, round-robin -> grants alternate A,B,A,B; each rvalid 2 cycles after its gnt; never both gnt.
REQ-033 Same as REQ-032 with ARB_FIXED_PRIO_EN and req_a never dropped -> only gnt_a; B is granted after req_a drops.
REQ-034 rst_n low in WAIT of read on A -> no rvalid_a, rdata_a=0, state IDLE, busy=0 next cycle.
REQ-035 Write addr 63 data 0xFF then read addr 63 back-to-back from port A -> rdata_a=0xFF; address wrap not applicable, addr 0 untouched.
